// File: rtl/decade_pkg.sv
// Shared types and constants for the decade counter sequencing controller.
// Holds the FSM states, command opcodes and BCD digit helpers.
package decade_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_START = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_t;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/decade_digit.sv
// One BCD decade: 4-bit register that counts 0..9 and flags its rollover.
module decade_digit
    import decade_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_inc_in,
    output logic [DIGIT_W-1:0] o_q,
    output logic               o_carry_out
);

    logic [DIGIT_W-1:0] r_q;

    // Digit register: clear has priority over increment; 9 rolls to 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 4'd0;
        end else if (i_clr) begin
            r_q <= 4'd0;
        end else if (i_inc_in) begin
            r_q <= (r_q == DIGIT_MAX) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign o_q         = r_q;
    assign o_carry_out = i_inc_in && (r_q == DIGIT_MAX);

endmodule

// File: rtl/decade_seq_ctrl.sv
// Command-driven sequencer for a chain of BCD decades: counts input events
// up to a programmable BCD target and reports done, wrap and bad-load events.
module decade_seq_ctrl
    import decade_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [1:0]                i_cmd_op,
    input  logic [DIGIT_W*DIGITS-1:0] i_cmd_data,
    input  logic                      i_stop,
    input  logic                      i_in,
    output logic [DIGIT_W*DIGITS-1:0] o_count,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_done_pulse,
    output logic                      o_wrap,
    output logic                      o_err
);

    localparam int CW = DIGIT_W * DIGITS;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_target;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_nx;
    logic [DIGITS-1:0] w_is9;
    logic [DIGITS-1:0] w_inc_in;
    logic [DIGITS-1:0] w_carry;
    logic            w_inc;
    logic            w_clr;
    logic            w_load;
    logic            w_err;
    logic            w_cmd_acc;
    logic            w_data_ok;
    logic            r_busy;
    logic            r_done;
    logic            r_done_pulse;
    logic            r_wrap;
    logic            r_err;

    assign o_cmd_ready = (r_state != ST_RUN);
    assign w_cmd_acc   = i_cmd_valid && o_cmd_ready;
    assign w_inc       = (r_state == ST_RUN) && !i_stop && i_in;

    // Increment enables look ahead over registered digits, so no comb path
    // runs through the carry outputs; carries still mark each digit's rollover.
    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign w_is9[g] = (w_count[g*DIGIT_W +: DIGIT_W] == DIGIT_MAX);
        if (g == 0) begin : g_first
            assign w_inc_in[g] = w_inc;
        end else begin : g_rest
            assign w_inc_in[g] = w_inc && (&w_is9[g-1:0]);
        end
        assign w_count_nx[g*DIGIT_W +: DIGIT_W] =
            !w_inc_in[g] ? w_count[g*DIGIT_W +: DIGIT_W] :
            w_carry[g]   ? 4'd0 : w_count[g*DIGIT_W +: DIGIT_W] + 4'd1;

        decade_digit u_digit (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_clr       (w_clr),
            .i_inc_in    (w_inc_in[g]),
            .o_q         (w_count[g*DIGIT_W +: DIGIT_W]),
            .o_carry_out (w_carry[g])
        );
    end

    // LOAD payload is accepted only if every nibble is a legal BCD digit.
    always_comb begin
        w_data_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            w_data_ok = w_data_ok && digit_ok(i_cmd_data[i*DIGIT_W +: DIGIT_W]);
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode and datapath controls.
    always_comb begin
        w_state_nx = r_state;
        w_clr      = 1'b0;
        w_load     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_stop) begin
                    w_state_nx = ST_PAUSE;
                end else if (w_inc && (w_count_nx == r_target)) begin
                    w_state_nx = ST_DONE;
                end else begin
                    w_state_nx = ST_RUN;
                end
            end
            ST_IDLE, ST_PAUSE, ST_DONE: begin
                if (w_cmd_acc) begin
                    case (i_cmd_op)
                        OP_CLEAR: begin
                            w_clr      = 1'b1;
                            w_state_nx = ST_IDLE;
                        end
                        OP_LOAD: begin
                            w_load = w_data_ok;
                            w_err  = !w_data_ok;
                            if (w_data_ok && (r_state == ST_DONE)) begin
                                w_state_nx = ST_IDLE;
                            end else begin
                                w_state_nx = r_state;
                            end
                        end
                        OP_START: begin
                            if (r_state == ST_DONE) begin
                                w_clr      = 1'b1;
                                w_state_nx = ST_RUN;
                            end else if ((r_state == ST_IDLE) && (w_count == r_target)) begin
                                w_state_nx = ST_DONE;
                            end else begin
                                w_state_nx = ST_RUN;
                            end
                        end
                        default: w_state_nx = r_state;
                    endcase
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Target register; resets to the all-nines value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_target <= {DIGITS{4'd9}};
        end else if (w_load) begin
            r_target <= i_cmd_data;
        end
    end

    // Registered status and pulses, aligned with the edge that updates count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_wrap       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_busy       <= (w_state_nx == ST_RUN);
            r_done       <= (w_state_nx == ST_DONE);
            r_done_pulse <= (w_state_nx == ST_DONE) && (r_state != ST_DONE);
            r_wrap       <= w_carry[DIGITS-1];
            r_err        <= w_err;
        end
    end

    assign o_count      = w_count;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_done_pulse = r_done_pulse;
    assign o_wrap       = r_wrap;
    assign o_err        = r_err;

endmodule

// File: tb/tb_decade_seq_ctrl.sv
// Bench for decade_seq_ctrl: integer-valued reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_decade_seq_ctrl;

    localparam int ND  = 4;
    localparam int W   = 4 * ND;
    localparam int MOD = 10000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_data = '0;
    logic         stop = 1'b0;
    logic         in_ev = 1'b0;
    logic         cmd_ready, busy, done, done_pulse, wrap, err;
    logic [W-1:0] count;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int st;
        int cnt;
        int tgt;
        bit dp;
        bit wr;
        bit er;
    } mst_t;

    mst_t m;

    decade_seq_ctrl #(.DIGITS(ND)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_op     (cmd_op),
        .i_cmd_data   (cmd_data),
        .i_stop       (stop),
        .i_in         (in_ev),
        .o_count      (count),
        .o_busy       (busy),
        .o_done       (done),
        .o_done_pulse (done_pulse),
        .o_wrap       (wrap),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < ND; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [W-1:0] d);
        for (int i = 0; i < ND; i++) if (d[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] d);
        int v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(d[i*4 +: 4]);
        return v;
    endfunction

    function automatic mst_t reset_state();
        mst_t r;
        r.st = S_IDLE; r.cnt = 0; r.tgt = MOD - 1;
        r.dp = 1'b0; r.wr = 1'b0; r.er = 1'b0;
        return r;
    endfunction

    function automatic mst_t step(input mst_t s, input bit v, input logic [1:0] op,
                                  input logic [W-1:0] d, input bit stp, input bit inn);
        mst_t n = s;
        n.dp = 1'b0; n.wr = 1'b0; n.er = 1'b0;
        if (s.st == S_RUN) begin
            if (stp) begin
                n.st = S_PAUSE;
            end else if (inn) begin
                n.cnt = (s.cnt + 1) % MOD;
                n.wr  = (s.cnt == MOD - 1);
                if (n.cnt == s.tgt) begin
                    n.st = S_DONE;
                    n.dp = 1'b1;
                end
            end
        end else if (v) begin
            case (op)
                2'd0: begin n.cnt = 0; n.st = S_IDLE; end
                2'd1: begin
                    if (!bcd_ok(d)) n.er = 1'b1;
                    else begin
                        n.tgt = from_bcd(d);
                        if (s.st == S_DONE) n.st = S_IDLE;
                    end
                end
                2'd2: begin
                    if (s.st == S_IDLE) begin
                        if (s.cnt == s.tgt) begin n.st = S_DONE; n.dp = 1'b1; end
                        else n.st = S_RUN;
                    end else if (s.st == S_PAUSE) n.st = S_RUN;
                    else begin n.cnt = 0; n.st = S_RUN; end
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    // Reference model advances on the same edges as the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) m <= reset_state();
        else     m <= step(m, cmd_valid, cmd_op, cmd_data, stop, in_ev);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_count", 32'(count), 32'(to_bcd(m.cnt)));
            check("m_ready", 32'(cmd_ready), 32'(m.st != S_RUN));
            check("m_busy", 32'(busy), 32'(m.st == S_RUN));
            check("m_done", 32'(done), 32'(m.st == S_DONE));
            check("m_done_pulse", 32'(done_pulse), 32'(m.dp));
            check("m_wrap", 32'(wrap), 32'(m.wr));
            check("m_err", 32'(err), 32'(m.er));
        end
    end

    task automatic drive(input bit v, input logic [1:0] op, input logic [W-1:0] d,
                         input bit s, input bit n);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_data = d; stop = s; in_ev = n;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, '0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        check("rst_count", 32'(count), 32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);

        // Bad LOAD in IDLE.
        drive(1'b1, 2'd1, 16'h00A3, 1'b0, 1'b0);
        tick();
        check("badload_err", 32'(err), 32'h1);
        check("badload_busy", 32'(busy), 32'h0);
        idle();
        tick();
        check("badload_err_clr", 32'(err), 32'h0);

        // Basic count to 0012.
        drive(1'b1, 2'd1, 16'h0012, 1'b0, 1'b0);
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        repeat (12) drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        tick();
        check("basic_count", 32'(count), 32'h0012);
        check("basic_dp", 32'(done_pulse), 32'h1);
        check("basic_busy", 32'(busy), 32'h0);
        idle();
        tick();
        check("basic_dp_clr", 32'(done_pulse), 32'h0);
        check("basic_done_held", 32'(done), 32'h1);

        // Stop wins over in.
        drive(1'b1, 2'd0, '0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 16'h0100, 1'b0, 1'b0);
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        repeat (5) drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, '0, 1'b1, 1'b1);
        tick();
        check("stop_count", 32'(count), 32'h0005);
        check("stop_busy", 32'(busy), 32'h0);
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        tick();
        check("resume_count", 32'(count), 32'h0006);

        // Command during RUN is not accepted.
        drive(1'b1, 2'd0, '0, 1'b0, 1'b0);
        tick();
        check("run_ready", 32'(cmd_ready), 32'h0);
        check("run_cmd_ignored", 32'(count), 32'h0006);

        // Asynchronous reset mid-count at 0042.
        repeat (36) drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        tick();
        check("pre_rst_count", 32'(count), 32'h0042);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'h0);
        check("arst_ready", 32'(cmd_ready), 32'h1);
        check("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Ripple through all digits and wrap to a 0000 target.
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, '0, 1'b1, 1'b0);
        drive(1'b1, 2'd1, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        repeat (9998) drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        tick();
        check("ripple_9999", 32'(count), 32'h9999);
        drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        tick();
        check("wrap_count", 32'(count), 32'h0000);
        check("wrap_pulse", 32'(wrap), 32'h1);
        check("wrap_dp", 32'(done_pulse), 32'h1);

        // Immediate match at START, then restart from DONE.
        drive(1'b1, 2'd0, '0, 1'b0, 1'b0);
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        tick();
        check("imm_dp", 32'(done_pulse), 32'h1);
        check("imm_done", 32'(done), 32'h1);
        drive(1'b1, 2'd2, '0, 1'b0, 1'b0);
        tick();
        check("restart_busy", 32'(busy), 32'h1);
        check("restart_count", 32'(count), 32'h0000);
        drive(1'b0, 2'd0, '0, 1'b0, 1'b1);
        tick();
        check("restart_first", 32'(count), 32'h0001);

        // Random traffic against the model.
        drive(1'b1, 2'd0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 3) != 0) ? to_bcd(int'($urandom_range(0, 40)))
                                            : W'($urandom);
            drive($urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), d,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
        end
        idle();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
